// File: rtl/ibex_axi4l_master_if.sv
// AXI4-Lite channel bundle shared by the LSU bridge and the peripheral fabric.
interface axi4l_if (input logic aclk);
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input aclk,
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/ibex_axi4l_master.sv
// Ibex LSU req/gnt data port to AXI4-Lite initiator, one transaction in flight.
module ibex_axi4l_master #(
  parameter bit ADDR_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  axi4l_if.master     axi
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;

  state_e      state;
  logic [31:0] req_addr;
  logic        aw_done;
  logic        w_done;

  assign req_addr   = ADDR_ALIGN ? {data_addr_i[31:2], 2'b00} : data_addr_i;
  assign data_gnt_o = data_req_i && (state == IDLE);
  assign axi.awprot = 3'b000;
  assign axi.arprot = 3'b000;

  // A channel counts as done if it already handshook or handshakes this cycle.
  assign aw_done = !axi.awvalid || axi.awready;
  assign w_done  = !axi.wvalid  || axi.wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      axi.awaddr    <= '0;
      axi.awvalid   <= 1'b0;
      axi.wdata     <= '0;
      axi.wstrb     <= '0;
      axi.wvalid    <= 1'b0;
      axi.bready    <= 1'b0;
      axi.araddr    <= '0;
      axi.arvalid   <= 1'b0;
      axi.rready    <= 1'b0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;
    end else begin
      data_rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req_i) begin
            if (data_we_i) begin
              axi.awaddr  <= req_addr;
              axi.wdata   <= data_wdata_i;
              axi.wstrb   <= data_be_i;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              state       <= WR_REQ;
            end else begin
              axi.araddr  <= req_addr;
              axi.arvalid <= 1'b1;
              state       <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (axi.awready) axi.awvalid <= 1'b0;
          if (axi.wready)  axi.wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            axi.bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            axi.bready    <= 1'b0;
            data_rvalid_o <= 1'b1;
            data_err_o    <= (axi.bresp != 2'b00);
            state         <= IDLE;
          end
        end
        RD_REQ: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (axi.rvalid) begin
            axi.rready    <= 1'b0;
            data_rvalid_o <= 1'b1;
            data_rdata_o  <= axi.rdata;
            data_err_o    <= (axi.rresp != 2'b00);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_axi4l_master.sv
// Directed bench: AXI4-Lite slave with programmable ready delays, response model, per-cycle compare.
module tb_ibex_axi4l_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  always #5 clk = ~clk;

  axi4l_if axi (.aclk(clk));

  ibex_axi4l_master #(.ADDR_ALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .axi(axi)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- slave ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic [31:0] mem [logic [31:0]];

  function automatic bit mapped(input logic [31:0] a);
    return (a >= 32'h4000_0000) && (a < 32'h4000_0100);
  endfunction

  initial begin
    int aw_wait, w_wait, ar_wait;
    logic hs_aw, hs_w, hs_b, hs_ar, hs_r, aw_got, w_got;
    aw_wait = 0; w_wait = 0; ar_wait = 0; aw_got = 0; w_got = 0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = 0;
    mem[32'h4000_0004] = 32'h1234_5678;
    forever begin
      @(posedge clk);
      hs_aw = axi.awvalid && axi.awready;
      hs_w  = axi.wvalid && axi.wready;
      hs_b  = axi.bvalid && axi.bready;
      hs_ar = axi.arvalid && axi.arready;
      hs_r  = axi.rvalid && axi.rready;
      if (hs_aw) s_awaddr = axi.awaddr;
      if (hs_w) begin s_wdata = axi.wdata; s_wstrb = axi.wstrb; end
      if (hs_ar) s_araddr = axi.araddr;
      #1;
      if (!rst_n) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0; aw_got = 0; w_got = 0;
        axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
      end else begin
        if (hs_aw) aw_got = 1;
        if (hs_w)  w_got = 1;
        if (hs_b)  axi.bvalid = 0;
        if (hs_r)  axi.rvalid = 0;
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0;
          axi.bvalid = 1;
          axi.bresp = mapped(s_awaddr) ? 2'b00 : 2'b10;
          if (mapped(s_awaddr)) begin
            if (!mem.exists(s_awaddr)) mem[s_awaddr] = '0;
            for (int b = 0; b < 4; b++)
              if (s_wstrb[b]) mem[s_awaddr][8*b +: 8] = s_wdata[8*b +: 8];
          end
        end
        if (hs_ar) begin
          axi.rvalid = 1;
          axi.rresp = mapped(s_araddr) ? 2'b00 : 2'b10;
          axi.rdata = !mapped(s_araddr) ? 32'hDEAD_0BAD :
                      mem.exists(s_araddr) ? mem[s_araddr] : 32'h0;
        end
        axi.awready = axi.awvalid && (aw_wait >= aw_dly);
        axi.wready  = axi.wvalid && (w_wait >= w_dly);
        axi.arready = axi.arvalid && (ar_wait >= ar_dly);
        aw_wait = axi.awvalid ? aw_wait + 1 : 0;
        w_wait  = axi.wvalid ? w_wait + 1 : 0;
        ar_wait = axi.arvalid ? ar_wait + 1 : 0;
      end
    end
  end

  // ---------------- response model ----------------
  logic        m_busy, m_rv, m_err;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_rv <= 0; m_err <= 0; m_rdata <= '0;
      m_addr <= '0; m_wdata <= '0; m_be <= '0;
    end else begin
      m_rv <= 0;
      if (data_req_i && !m_busy) begin
        m_busy  <= 1;
        m_addr  <= data_addr_i & 32'hFFFF_FFFC;
        m_wdata <= data_wdata_i;
        m_be    <= data_be_i;
      end
      if (axi.bvalid && axi.bready) begin
        m_busy <= 0; m_rv <= 1; m_err <= (axi.bresp != 2'b00);
      end
      if (axi.rvalid && axi.rready) begin
        m_busy <= 0; m_rv <= 1; m_err <= (axi.rresp != 2'b00); m_rdata <= axi.rdata;
      end
    end
  end

  int aw_hi_tot = 0, w_hi_tot = 0, pulse_tot = 0;

  always @(negedge clk) begin
    chk("gnt", data_gnt_o, data_req_i && !m_busy);
    chk("rvalid", data_rvalid_o, m_rv);
    if (m_rv) chk("err", data_err_o, m_err);
    chk("rdata_hold", data_rdata_o, m_rdata);
    if (axi.awvalid) chk("awaddr", axi.awaddr, m_addr);
    if (axi.wvalid) begin
      chk("wdata", axi.wdata, m_wdata);
      chk("wstrb", axi.wstrb, m_be);
    end
    if (axi.arvalid) chk("araddr", axi.araddr, m_addr);
    chk("ready_when_idle", (axi.bready || axi.rready) && !m_busy, 0);
    aw_hi_tot <= aw_hi_tot + int'(axi.awvalid);
    w_hi_tot  <= w_hi_tot + int'(axi.wvalid);
    pulse_tot <= pulse_tot + int'(data_rvalid_o);
  end

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic err, output logic [31:0] rdata,
                     output int lat);
    int n;
    @(posedge clk); #2;
    data_req_i = 1; data_we_i = we; data_addr_i = addr; data_wdata_i = wdata; data_be_i = be;
    n = 0;
    @(negedge clk);
    while (!data_gnt_o && n < 50) begin @(negedge clk); n++; end
    if (!data_gnt_o) chk("gnt_timeout", 0, 1);
    @(posedge clk); #2;
    data_req_i = 0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (data_rvalid_o) break;
    end
    if (!data_rvalid_o) chk("rvalid_timeout", 0, 1);
    err = data_err_o;
    rdata = data_rdata_o;
  endtask

  initial begin
    logic        err;
    logic [31:0] rd;
    int          lat, aw0, w0, p0;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic        err;
    logic [31:0] rd;
    int          lat, aw0, w0, p0;

    // reset state
    @(negedge clk);
    chk("rst_rvalid", data_rvalid_o, 0);
    chk("rst_err", data_err_o, 0);
    chk("rst_rdata", data_rdata_o, 0);
    chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
    @(posedge clk); #2; rst_n = 1;

    // zero-wait store
    txn(1, 32'h4000_0008, 32'hDEAD_BEEF, 4'hF, err, rd, lat);
    chk("st_lat", lat, 3);
    chk("st_err", err, 0);
    chk("st_awaddr", s_awaddr, 32'h4000_0008);
    chk("st_wstrb", s_wstrb, 4'hF);
    chk("st_rdata_kept", rd, 32'h0);

    // zero-wait loads
    txn(0, 32'h4000_0004, 32'h0, 4'hF, err, rd, lat);
    chk("ld_lat", lat, 3);
    chk("ld_araddr", s_araddr, 32'h4000_0004);
    chk("ld_rdata", rd, 32'h1234_5678);
    chk("ld_err", err, 0);
    txn(0, 32'h4000_0008, 32'h0, 4'hF, err, rd, lat);
    chk("ld_back_store", rd, 32'hDEAD_BEEF);

    // AW delayed 3, W delayed 1
    aw_dly = 3; w_dly = 1;
    #1; aw0 = aw_hi_tot; w0 = w_hi_tot; p0 = pulse_tot;
    txn(1, 32'h4000_000C, 32'hA5A5_5A5A, 4'hF, err, rd, lat);
    repeat (2) @(negedge clk);
    #1;
    chk("dly_aw_cycles", aw_hi_tot - aw0, 4);
    chk("dly_w_cycles", w_hi_tot - w0, 2);
    chk("dly_pulses", pulse_tot - p0, 1);
    chk("dly_lat", lat, 6);
    chk("dly_err", err, 0);
    aw_dly = 0; w_dly = 0;

    // unmapped load, then a mapped one
    txn(0, 32'h4000_0FFC, 32'h0, 4'hF, err, rd, lat);
    chk("slverr_araddr", s_araddr, 32'h4000_0FFC);
    chk("slverr_err", err, 1);
    chk("slverr_rdata", rd, 32'hDEAD_0BAD);
    txn(0, 32'h4000_000C, 32'h0, 4'hF, err, rd, lat);
    chk("after_err_err", err, 0);
    chk("after_err_rdata", rd, 32'hA5A5_5A5A);

    // byte store, address aligned down
    txn(1, 32'h4000_0002, 32'h11AB_2233, 4'b0100, err, rd, lat);
    chk("byte_awaddr", s_awaddr, 32'h4000_0000);
    chk("byte_wstrb", s_wstrb, 4'b0100);
    txn(0, 32'h4000_0000, 32'h0, 4'hF, err, rd, lat);
    chk("byte_readback", rd, 32'h00AB_0000);

    // empty strobe still completes and writes nothing
    txn(1, 32'h4000_0004, 32'hFFFF_FFFF, 4'b0000, err, rd, lat);
    chk("be0_lat", lat, 3);
    chk("be0_err", err, 0);
    txn(0, 32'h4000_0004, 32'h0, 4'hF, err, rd, lat);
    chk("be0_readback", rd, 32'h1234_5678);

    // unmapped store
    txn(1, 32'h4000_0200, 32'h1, 4'hF, err, rd, lat);
    chk("wr_slverr", err, 1);

    // reset during WR_REQ
    aw_dly = 5; w_dly = 5;
    @(posedge clk); #2;
    data_req_i = 1; data_we_i = 1; data_addr_i = 32'h4000_0010;
    data_wdata_i = 32'hCAFE_F00D; data_be_i = 4'hF;
    @(posedge clk); #2;
    data_req_i = 0;
    @(negedge clk);
    chk("rst_mid_awvalid_pre", axi.awvalid, 1);
    #1; rst_n = 0; #1;
    chk("rst_mid_awvalid", axi.awvalid, 0);
    chk("rst_mid_wvalid", axi.wvalid, 0);
    #1; p0 = pulse_tot;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_no_pulse", pulse_tot - p0, 0);
    aw_dly = 0; w_dly = 0;
    @(posedge clk); #2; rst_n = 1;
    txn(0, 32'h4000_0008, 32'h0, 4'hF, err, rd, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rdata", rd, 32'hDEAD_BEEF);
    chk("post_rst_err", err, 0);
    txn(0, 32'h4000_0010, 32'h0, 4'hF, err, rd, lat);
    chk("aborted_store_absent", rd, 32'h0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ibex_axi4l_master.md
Name: ibex_axi4l_master

Overview:
- Bridges the Ibex core's LSU request/grant data interface onto the SoC AXI4-Lite fabric as an AXI4-Lite initiator.
- Sits between the core data port and the interconnect that feeds the AXI4-Lite peripherals (timer, UART, GPIO, RAM).
- Supports one outstanding transaction at a time.
- Converts each granted load/store into a complete AXI4-Lite read or write and returns the response as data_rvalid_o / data_err_o.

Parameters:
- ADDR_ALIGN, 1, when 1 force awaddr[1:0]/araddr[1:0] to 2'b00; when 0 pass data_addr_i unchanged.

Ports:
- clk  input  1  system clock; the interface clock axi.aclk is driven from the same net.
- rst_n  input  1  asynchronous active-low reset.
- data_req_i  input  1  core request.
- data_gnt_o  output  1  grant, combinational.
- data_we_i  input  1  1 = store, 0 = load.
- data_be_i  input  4  byte enables.
- data_addr_i  input  32  byte address.
- data_wdata_i  input  32  store data.
- data_rvalid_o  output  1  response valid, one-cycle pulse.
- data_rdata_o  output  32  load data.
- data_err_o  output  1  bus error, qualified by data_rvalid_o.
- axi  modport axi4l_if.master  -  AXI4-Lite initiator side: AW, W, B, AR, R channels.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). All state flops reset on negedge rst_n.
- Reset values:
  - awvalid, wvalid, arvalid = 0; bready, rready = 0.
  - data_rvalid_o = 0, data_err_o = 0, data_rdata_o = 0.
  - state = IDLE.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - data_gnt_o = data_req_i; data_gnt_o is 0 in every other state.
  - On grant, latch addr (aligned per ADDR_ALIGN), wdata and be into axi.awaddr/wdata/wstrb or axi.araddr.
  - we=1: next state WR_REQ, awvalid=1, wvalid=1 from the next cycle.
  - we=0: next state RD_REQ, arvalid=1 from the next cycle.
- WR_REQ:
  - awvalid and wvalid drop independently on their own handshake (valid && ready).
  - Payload is held stable while valid is high.
  - When both handshakes are complete, including same-cycle completion, go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: next cycle data_rvalid_o=1 and data_err_o=(bresp != OKAY); data_rdata_o unchanged; state goes to IDLE.
- RD_REQ: arvalid held until arready, then go to RD_RESP.
- RD_RESP:
  - rready=1.
  - On rvalid: next cycle data_rvalid_o=1, data_rdata_o=rdata, data_err_o=(rresp != OKAY); state goes to IDLE.
- bready/rready are driven only in the response states. They go low in the cycle after the handshake.
- data_rvalid_o is a single-cycle pulse. data_rdata_o holds its value until the next read response; it is updated on error responses too.
- Latency with a zero-wait slave (ready held high, response in the cycle after the handshake):
  - req/gnt at cycle T.
  - AW/W or AR handshake at T+1.
  - B/R valid at T+2.
  - data_rvalid_o at T+3.
- Back-to-back: state is IDLE in the cycle data_rvalid_o pulses, so a new req may be granted in that same cycle.
- Stalls:
  - A slave holding ready low keeps valid and payload stable indefinitely; there is no timeout.
  - awready and wready may arrive in any order, any number of cycles apart.
- Strobes: wstrb = data_be_i unmodified, including 4'b0000, which still produces a full AXI write and a response.
- Reset mid-operation: all valids/readies drop asynchronously and state returns to IDLE. The in-flight transaction is abandoned with no data_rvalid_o; the fabric is reset by the same rst_n.
- No combinational path from axi inputs to axi outputs. data_gnt_o depends only on data_req_i and state.

Test Plan:
- Store 0xDEADBEEF to 0x4000_0008, be=4'hF, zero-wait slave, OKAY:
  - awaddr=0x4000_0008, wstrb=4'hF at T+1.
  - data_rvalid_o=1, data_err_o=0 at T+3.
- Load from 0x4000_0004, slave returns rdata=0x1234_5678, OKAY:
  - araddr=0x4000_0004.
  - data_rdata_o=0x1234_5678, data_rvalid_o=1 at T+3.
- Store with awready delayed 3 cycles and wready delayed 1 cycle:
  - wvalid drops after its handshake; awvalid stays high until its handshake.
  - Exactly one data_rvalid_o pulse after bvalid.
- Load from unmapped 0x4000_0FFC, rresp=SLVERR:
  - data_err_o=1 with data_rvalid_o.
  - Next load to a mapped address returns data_err_o=0.
- Byte store be=4'b0100, addr 0x4000_0002, ADDR_ALIGN=1:
  - awaddr=0x4000_0000, wstrb=4'b0100.
- Assert rst_n=0 during WR_REQ with awvalid=1:
  - awvalid/wvalid=0 immediately; no data_rvalid_o.
  - After release, a new load completes normally.
